// File: rtl/rf_pkg.sv
// Shared register-file types: writeback record passed from the ALU result
// path to the write queue and on to the 32x32 register bank.
package rf_pkg;

    localparam int RF_AW = 5;
    localparam int RF_DW = 32;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rf_fwd_match.sv
// Priority search over N candidate writes for one read address.
// Entry 0 is the oldest candidate and entry N-1 the youngest, so the
// youngest matching entry determines the forwarded data.
module rf_fwd_match #(
    parameter int N  = 5,
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic [AW-1:0]         addr,
    input  logic [N-1:0]          valid,
    input  logic [N-1:0][AW-1:0]  addrs,
    input  logic [N-1:0][DW-1:0]  datas,
    output logic                  hit,
    output logic [DW-1:0]         data
);

    // Walk from oldest to youngest; later matches override earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (addrs[i] == addr)) begin
                hit  = 1'b1;
                data = datas[i];
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Writeback queue in front of the register bank's single write port.
// Buffers {addr, data} writes, issues one per cycle in FIFO order through
// a registered output stage, and forwards the newest pending value for two
// read addresses so readers never see a stale bank entry.
module rf_write_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    input  logic                      hold,
    output logic [AW-1:0]             aw,
    output logic [DW-1:0]             dataIn,
    output logic                      we,
    input  logic [AW-1:0]             ar1,
    input  logic [AW-1:0]             ar2,
    output logic                      hit1,
    output logic                      hit2,
    output logic [DW-1:0]             fwd1,
    output logic [DW-1:0]             fwd2,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Storage uses the shared record type; addresses and data are sized
    // to the record on the way in and back to AW/DW on the way out.
    rf_wr_t           mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             push;
    logic             pop;

    logic [DEPTH:0]           srch_valid;
    logic [DEPTH:0][AW-1:0]   srch_addr;
    logic [DEPTH:0][DW-1:0]   srch_data;

    // A full queue can still accept a write when the head drains this cycle.
    assign pop      = !hold && (count != '0);
    assign in_ready = (count < CW'(DEPTH)) || pop;
    assign push     = in_valid && in_ready;

    // Queue storage: written at the tail, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{addr: RF_AW'(in_addr), data: RF_DW'(in_data)};
        end
    end

    // Pointers, occupancy and the registered bank write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            we     <= 1'b0;
            aw     <= '0;
            dataIn <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head   <= head + PW'(1);
                aw     <= AW'(mem[head].addr);
                dataIn <= DW'(mem[head].data);
                we     <= 1'b1;
            end else begin
                we     <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Candidate list for forwarding, oldest first: output stage, then the
    // queue from head to the newest occupied slot.
    always_comb begin
        srch_valid    = '0;
        srch_addr     = '0;
        srch_data     = '0;
        srch_valid[0] = we;
        srch_addr[0]  = aw;
        srch_data[0]  = dataIn;
        for (int i = 0; i < DEPTH; i++) begin
            srch_valid[i+1] = (CW'(i) < count);
            srch_addr[i+1]  = AW'(mem[head + PW'(i)].addr);
            srch_data[i+1]  = DW'(mem[head + PW'(i)].data);
        end
    end

    rf_fwd_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_fwd1 (
        .addr  (ar1),
        .valid (srch_valid),
        .addrs (srch_addr),
        .datas (srch_data),
        .hit   (hit1),
        .data  (fwd1)
    );

    rf_fwd_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_fwd2 (
        .addr  (ar2),
        .valid (srch_valid),
        .addrs (srch_addr),
        .datas (srch_data),
        .hit   (hit2),
        .data  (fwd2)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: accepted writes go into a
// scoreboard queue, a monitor checks every bank write against it, and the
// directed sequence checks occupancy, ready and forwarding.
module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_data;
    logic            hold;
    logic [AW-1:0]   aw;
    logic [DW-1:0]   dataIn;
    logic            we;
    logic [AW-1:0]   ar1;
    logic [AW-1:0]   ar2;
    logic            hit1;
    logic            hit2;
    logic [DW-1:0]   fwd1;
    logic [DW-1:0]   fwd2;
    logic [2:0]      count;

    int n_cmp = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    rf_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .hold     (hold),
        .aw       (aw),
        .dataIn   (dataIn),
        .we       (we),
        .ar1      (ar1),
        .ar2      (ar2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard producer: record each accepted write; reset discards all.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back({in_addr, in_data});
        end
    end

    // Scoreboard consumer: every bank write must match the oldest record.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", aw, dataIn);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check_output("write_addr", 64'(aw), 64'(e[AW+DW-1:DW]));
                check_output("write_data", 64'(dataIn), 64'(e[DW-1:0]));
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_stimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic h);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        hold     = h;
    endtask

    initial begin
        int sent;
        int cyc;
        logic acc;
        bit drained;

        rst_n = 1'b0;
        ar1   = '0;
        ar2   = '0;
        apply_stimulus(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        check_output("rst_count", 64'(count), 64'(0));
        check_output("rst_we", 64'(we), 64'(0));
        check_output("rst_aw", 64'(aw), 64'(0));
        check_output("rst_dataIn", 64'(dataIn), 64'(0));
        rst_n = 1'b1;
        #1;
        check_output("post_rst_ready", 64'(in_ready), 64'(1));

        // Single write
        @(negedge clk);
        apply_stimulus(1'b1, 5'd3, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b0, '0, '0, 1'b0);
        check_output("single_count", 64'(count), 64'(1));
        @(negedge clk);
        check_output("single_we", 64'(we), 64'(1));
        check_output("single_aw", 64'(aw), 64'(3));
        check_output("single_data", 64'(dataIn), 64'(32'hDEADBEEF));
        @(negedge clk);
        check_output("single_we_off", 64'(we), 64'(0));
        check_output("single_count0", 64'(count), 64'(0));

        // Fill under hold
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, AW'(i), DW'(32'h10 * i), 1'b1);
            @(negedge clk);
        end
        apply_stimulus(1'b0, '0, '0, 1'b1);
        #1;
        check_output("full_count", 64'(count), 64'(4));
        check_output("full_ready", 64'(in_ready), 64'(0));

        // Release hold and push while full
        apply_stimulus(1'b1, 5'd5, 32'h50, 1'b0);
        #1;
        check_output("full_pop_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        apply_stimulus(1'b0, '0, '0, 1'b0);
        check_output("pushpop_count", 64'(count), 64'(4));
        for (int k = 1; k <= 5; k++) begin
            check_output("drain_we", 64'(we), 64'(1));
            check_output("drain_aw", 64'(aw), 64'(k));
            @(negedge clk);
        end
        check_output("drain_we_off", 64'(we), 64'(0));
        check_output("drain_count0", 64'(count), 64'(0));

        // Forwarding priority
        ar1 = 5'd7;
        ar2 = 5'd8;
        apply_stimulus(1'b1, 5'd7, 32'h1, 1'b1);
        #1;
        check_output("fwd_pushing_invisible", 64'(hit1), 64'(0));
        @(negedge clk);
        apply_stimulus(1'b1, 5'd7, 32'h2, 1'b1);
        #1;
        check_output("fwd_first_only", 64'(fwd1), 64'(1));
        @(negedge clk);
        apply_stimulus(1'b0, '0, '0, 1'b1);
        #1;
        check_output("fwd_hit1", 64'(hit1), 64'(1));
        check_output("fwd_fwd1", 64'(fwd1), 64'(2));
        check_output("fwd_hit2", 64'(hit2), 64'(0));
        check_output("fwd_fwd2", 64'(fwd2), 64'(0));
        hold = 1'b0;
        @(negedge clk);
        check_output("fwd_queue_over_stage", 64'(fwd1), 64'(2));
        @(negedge clk);
        check_output("fwd_stage_hit", 64'(hit1), 64'(1));
        check_output("fwd_stage_data", 64'(fwd1), 64'(2));
        @(negedge clk);
        check_output("fwd_gone_hit", 64'(hit1), 64'(0));
        check_output("fwd_gone_data", 64'(fwd1), 64'(0));

        // Wrap-around stream with alternating hold
        sent = 0;
        cyc  = 0;
        while (sent < 10 && cyc < 100) begin
            apply_stimulus(1'b1, AW'(10 + sent), DW'(32'h100 + sent), cyc[0]);
            #1;
            acc = in_ready;
            @(negedge clk);
            if (acc) sent++;
            check_output("wrap_count_le4", 64'(count <= 3'd4), 64'(1));
            cyc++;
        end
        check_output("wrap_sent", 64'(sent), 64'(10));
        apply_stimulus(1'b0, '0, '0, 1'b0);
        drained = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && we == 1'b0) begin
                drained = 1'b1;
                break;
            end
        end
        check_output("wrap_drained", 64'(drained), 64'(1));

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, AW'(20 + i), DW'(32'hA0 + i), 1'b1);
            @(negedge clk);
        end
        apply_stimulus(1'b0, '0, '0, 1'b1);
        #1;
        check_output("midrst_count3", 64'(count), 64'(3));
        rst_n = 1'b0;
        apply_stimulus(1'b1, 5'd23, 32'hA3, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, '0, '0, 1'b0);
        check_output("midrst_count", 64'(count), 64'(0));
        check_output("midrst_we", 64'(we), 64'(0));
        check_output("midrst_aw", 64'(aw), 64'(0));
        check_output("midrst_dataIn", 64'(dataIn), 64'(0));
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check_output("midrst_no_write", 64'(we), 64'(0));
        end

        check_output("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
